pc_sequencer: RTL and testbench

Fetch sequencer for the 8-bit program counter. It steps the PC through fetch cycles with a memory request/acknowledge handshake and presents each fetched instruction to the decoder with a valid/ready handshake. It also applies decoder branch commands (jump, call, return, rewind) to the PC, using an internal return-address stack. It is the only block that drives the PC's control inputs.

---
 rtl/pc_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch sequencer: walks the program counter through memory fetches and hands
// each instruction to the decoder. It also applies jump/call/return/rewind commands.
module pc_sequencer #(
  parameter int RAS_DEPTH = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              pc_clk,
  input  logic              pc_rst,
  input  logic              start,
  input  logic              halt_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              instr_valid,
  output logic [7:0]        instr,
  input  logic              instr_ready,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_done,
  input  logic [ADDR_W-1:0] pc_value,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              pc_rd_en,
  output logic              pc_wr_en,
  output logic              pc_dir,
  output logic              pc_count,
  output logic              busy,
  output logic              stack_err
);

  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = $clog2(RAS_DEPTH);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  localparam logic [1:0] BR_JUMP   = 2'b00;
  localparam logic [1:0] BR_CALL   = 2'b01;
  localparam logic [1:0] BR_RETURN = 2'b10;
  localparam logic [1:0] BR_REWIND = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_ADV,
    S_BRANCH
  } state_t;

  state_t              state, state_nxt;
  logic                halt_pend;
  logic [7:0]          instr_q;
  logic [1:0]          br_type_q;
  logic [ADDR_W-1:0]   br_target_q;
  logic [ADDR_W-1:0]   ras [RAS_DEPTH];
  logic [SP_W-1:0]     sp;
  logic [IDX_W-1:0]    push_idx, top_idx;
  logic                stack_full, stack_empty;
  logic                do_push, do_pop, br_err;

  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign push_idx    = IDX_W'(sp);
  assign top_idx     = IDX_W'(sp - SP_ONE);

  assign do_push = (state == S_BRANCH) && (br_type_q == BR_CALL)   && !stack_full;
  assign do_pop  = (state == S_BRANCH) && (br_type_q == BR_RETURN) && !stack_empty;
  assign br_err  = (state == S_BRANCH) &&
                   (((br_type_q == BR_CALL) && stack_full) ||
                    ((br_type_q == BR_RETURN) && stack_empty));

  assign busy     = (state != S_IDLE);
  assign pc_rd_en = (state != S_IDLE);
  assign instr    = instr_q;

  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;
    br_done     = 1'b0;
    pc_load_val = '0;
    pc_wr_en    = 1'b0;
    pc_dir      = 1'b0;
    pc_count    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = pc_value;
        if (mem_ack) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) state_nxt = br_valid ? S_BRANCH : S_ADV;
      end
      S_ADV: begin
        pc_count  = 1'b1;
        state_nxt = halt_pend ? S_IDLE : S_REQ;
      end
      S_BRANCH: begin
        br_done   = 1'b1;
        state_nxt = halt_pend ? S_IDLE : S_REQ;
        case (br_type_q)
          BR_JUMP: begin
            pc_wr_en    = 1'b1;
            pc_load_val = br_target_q;
          end
          BR_CALL: begin
            // A call that would overflow the stack degrades to a plain advance.
            if (stack_full) begin
              pc_count = 1'b1;
            end else begin
              pc_wr_en    = 1'b1;
              pc_load_val = br_target_q;
            end
          end
          BR_RETURN: begin
            if (stack_empty) begin
              pc_count = 1'b1;
            end else begin
              pc_wr_en    = 1'b1;
              pc_load_val = ras[top_idx];
            end
          end
          default: pc_dir = 1'b1;
        endcase
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pc_clk or posedge pc_rst) begin
    if (pc_rst) begin
      state     <= S_IDLE;
      halt_pend <= 1'b0;
      sp        <= '0;
      stack_err <= 1'b0;
      instr_q   <= '0;
    end else begin
      state <= state_nxt;
      // A halt seen together with start still lets one instruction run.
      if ((state != S_IDLE) && (state_nxt == S_IDLE))
        halt_pend <= 1'b0;
      else if (halt_req && ((state != S_IDLE) || start))
        halt_pend <= 1'b1;
      if ((state == S_IDLE) && start)
        stack_err <= 1'b0;
      else if (br_err)
        stack_err <= 1'b1;
      if ((state == S_REQ) && mem_ack)
        instr_q <= mem_data;
      if (do_push)
        sp <= sp + SP_ONE;
      else if (do_pop)
        sp <= sp - SP_ONE;
    end
  end

  always_ff @(posedge pc_clk) begin
    if ((state == S_HOLD) && instr_ready && br_valid) begin
      br_type_q   <= br_type;
      br_target_q <= br_target;
    end
    if (do_push)
      ras[push_idx] <= pc_value + ADDR_W'(1);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random instruction
// streams, checked against a queue-based model of PC, return stack and halt.
module tb_pc_sequencer;
  localparam int RAS_DEPTH = 4;
  localparam int ADDR_W    = 8;
  localparam logic [1:0] JMP = 2'b00, CAL = 2'b01, RET = 2'b10, RWD = 2'b11;

  logic              pc_clk = 1'b0;
  logic              pc_rst = 1'b1;
  logic              start = 1'b0, halt_req = 1'b0;
  logic              mem_req, mem_ack = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = '0;
  logic              instr_valid, instr_ready = 1'b0;
  logic [7:0]        instr;
  logic              br_valid = 1'b0, br_done;
  logic [1:0]        br_type = '0;
  logic [ADDR_W-1:0] br_target = '0;
  logic [ADDR_W-1:0] pc_value, pc_load_val, pc_reg;
  logic              pc_rd_en, pc_wr_en, pc_dir, pc_count, busy, stack_err;

  pc_sequencer #(.RAS_DEPTH(RAS_DEPTH), .ADDR_W(ADDR_W)) dut (
    .pc_clk(pc_clk), .pc_rst(pc_rst), .start(start), .halt_req(halt_req),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .br_valid(br_valid), .br_type(br_type), .br_target(br_target), .br_done(br_done),
    .pc_value(pc_value), .pc_load_val(pc_load_val), .pc_rd_en(pc_rd_en),
    .pc_wr_en(pc_wr_en), .pc_dir(pc_dir), .pc_count(pc_count), .busy(busy),
    .stack_err(stack_err)
  );

  always #5 pc_clk = ~pc_clk;

  // The program counter the sequencer drives.
  always_ff @(posedge pc_clk or posedge pc_rst) begin
    if (pc_rst)        pc_reg <= '0;
    else if (pc_wr_en) pc_reg <= pc_load_val;
    else if (pc_count) pc_reg <= pc_reg + 8'd1;
    else if (pc_dir)   pc_reg <= pc_reg - 8'd1;
  end
  assign pc_value = pc_reg;

  // Reference state.
  logic [7:0] exp_pc;
  logic [7:0] ras_q[$];
  bit         exp_err, exp_halt, idle_m;
  int         n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge pc_clk);
    chk("pc_strobe_onehot", 32'($countones({pc_wr_en, pc_count, pc_dir}) <= 1), 1);
  endtask

  task automatic start_fetch(input logic with_halt);
    chk("idle_busy", busy, 0);
    start = 1'b1; halt_req = with_halt;
    tick();
    start = 1'b0; halt_req = 1'b0;
    exp_err = 1'b0; idle_m = 1'b0;
    if (with_halt) exp_halt = 1'b1;
    chk("start_latency", mem_req, 1);
    chk("stack_err_clr", stack_err, 0);
  endtask

  task automatic do_instr(input int ack_dly, input int rdy_dly, input logic bv,
                          input logic [1:0] bt, input logic [7:0] tgt,
                          input logic [7:0] d, input logic hreq);
    logic [7:0] npc, e_ld;
    logic       e_wr, e_cnt, e_dir;
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, exp_pc);
    chk("busy", busy, 1);
    chk("pc_rd_en", pc_rd_en, 1);
    if (hreq) begin halt_req = 1'b1; exp_halt = 1'b1; end
    for (int i = 0; i < ack_dly; i++) begin
      tick(); halt_req = 1'b0;
      chk("req_wait", mem_req, 1);
      chk("req_wait_quiet", {pc_wr_en, pc_count, pc_dir, br_done, instr_valid}, 0);
    end
    mem_ack = 1'b1; mem_data = d;
    tick();
    mem_ack = 1'b0; halt_req = 1'b0;
    chk("instr_valid", instr_valid, 1);
    chk("instr", instr, d);
    chk("req_drop", mem_req, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      mem_ack = 1'($urandom); mem_data = ~d; br_valid = 1'($urandom);
      tick();
      chk("hold_valid", instr_valid, 1);
      chk("hold_instr", instr, d);
      chk("hold_quiet", {pc_wr_en, pc_count, pc_dir, br_done}, 0);
    end
    mem_ack = 1'b0;
    instr_ready = 1'b1; br_valid = bv; br_type = bt; br_target = tgt;
    tick();
    instr_ready = 1'b0; br_valid = 1'b0;
    e_wr = 0; e_cnt = 0; e_dir = 0; e_ld = '0; npc = exp_pc + 8'd1;
    if (!bv) e_cnt = 1;
    else begin
      case (bt)
        JMP: begin e_wr = 1; e_ld = tgt; npc = tgt; end
        CAL: if (ras_q.size() == RAS_DEPTH) begin e_cnt = 1; exp_err = 1; end
             else begin ras_q.push_back(exp_pc + 8'd1); e_wr = 1; e_ld = tgt; npc = tgt; end
        RET: if (ras_q.size() == 0) begin e_cnt = 1; exp_err = 1; end
             else begin e_ld = ras_q.pop_back(); e_wr = 1; npc = e_ld; end
        default: begin e_dir = 1; npc = exp_pc - 8'd1; end
      endcase
    end
    chk("pc_wr_en", pc_wr_en, e_wr);
    chk("pc_count", pc_count, e_cnt);
    chk("pc_dir", pc_dir, e_dir);
    chk("br_done", br_done, bv);
    if (e_wr) chk("pc_load_val", pc_load_val, e_ld);
    chk("valid_off", instr_valid, 0);
    chk("addr_off", mem_addr, 0);
    tick();
    exp_pc = npc;
    if (exp_halt) begin
      chk("halt_busy", busy, 0);
      chk("halt_req_off", mem_req, 0);
      chk("halt_rd_en", pc_rd_en, 0);
      exp_halt = 1'b0; idle_m = 1'b1;
    end else begin
      chk("refetch_req", mem_req, 1);
    end
    chk("stack_err", stack_err, exp_err);
  endtask

  initial begin
    exp_pc = '0; exp_err = 0; exp_halt = 0; idle_m = 1;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_instr", instr, 0);
    chk("rst_outs", {instr_valid, br_done, pc_rd_en, pc_wr_en, pc_dir, pc_count, stack_err}, 0);
    chk("rst_addr", mem_addr, 0);
    @(negedge pc_clk); pc_rst = 1'b0;
    tick();

    // Sequential fetch, jump, call/return, stack overflow/underflow, rewind wrap.
    start_fetch(0);
    for (int n = 0; n < 5; n++) do_instr(1, 0, 0, JMP, 0, 8'hA0 + 8'(n), 0);
    do_instr(0, 0, 1, JMP, 8'h40, 8'h11, 0);
    do_instr(0, 1, 1, JMP, 8'h10, 8'h12, 0);
    do_instr(0, 0, 1, CAL, 8'h80, 8'h13, 0);
    do_instr(1, 0, 1, RET, 8'h00, 8'h14, 0);
    for (int n = 0; n < 5; n++) do_instr(0, 0, 1, CAL, 8'h20 + 8'(n * 16), 8'h20, 0);
    for (int n = 0; n < 5; n++) do_instr(0, 0, 1, RET, 8'h00, 8'h30, 0);
    do_instr(0, 0, 1, JMP, 8'hFE, 8'h40, 0);
    do_instr(0, 0, 0, JMP, 8'h00, 8'h41, 0);
    do_instr(0, 0, 0, JMP, 8'h00, 8'h42, 0);
    do_instr(0, 0, 1, RWD, 8'h00, 8'h43, 0);
    do_instr(0, 0, 0, JMP, 8'h00, 8'h44, 0);

    // Halt during a slow fetch, ignored acks in IDLE, then reset mid-fetch.
    do_instr(3, 0, 0, JMP, 8'h00, 8'h50, 1);
    mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    chk("idle_ack_ignored", {busy, instr_valid, mem_req}, 0);
    start_fetch(0);
    tick();
    pc_rst = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_valid", instr_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_instr", instr, 0);
    tick();
    pc_rst = 1'b0;
    exp_pc = '0; ras_q.delete(); exp_err = 0; exp_halt = 0; idle_m = 1;
    tick();
    start_fetch(0);
    do_instr(0, 0, 0, JMP, 8'h00, 8'h60, 0);
    do_instr(0, 0, 1, JMP, 8'h30, 8'h61, 1);

    // Start and halt together: exactly one instruction.
    start_fetch(1);
    do_instr(0, 0, 0, JMP, 8'h00, 8'h70, 0);

    // Random instruction stream.
    for (int k = 0; k < 300; k++) begin
      if (idle_m) start_fetch(1'($urandom_range(0, 3) == 0));
      if (idle_m) continue;
      do_instr($urandom_range(0, 3), $urandom_range(0, 2),
               1'($urandom_range(0, 9) >= 5), 2'($urandom), 8'($urandom),
               8'($urandom), 1'($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
